fb_scan_ctrl: RTL

Sequencing controller for the 8-bit framebuffer RAM: it owns both RAM ports. It generates the raster read-address stream, absorbs the RAM's one-cycle read latency into a small prefetch FIFO, and presents pixels to the LCD timing engine over a valid/ready stream. It also accepts host pixel writes over a second valid/ready port, bounds-checks them and drives them onto the RAM write port.

---
 rtl/fb_scan_ctrl_pkg.sv | 23 ++
 rtl/fb_scan_ctrl_if.sv | 44 ++++
 rtl/fb_prefetch_fifo.sv | 74 +++++++
 rtl/fb_scan_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/fb_scan_ctrl_pkg.sv
// Shared types and constants for the framebuffer scan controller.
//   PX_W / ADDR_W  : pixel and RAM address widths
//   FB_SIZE_DEFAULT: default framebuffer size in pixels (320x240)
//   scan_state_t   : controller state encoding (IDLE, SCAN, DRAIN)
//   px_entry_t     : prefetch FIFO entry (pixel byte + end-of-frame flag)
package fb_scan_ctrl_pkg;

    localparam int unsigned PX_W            = 8;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned FB_SIZE_DEFAULT = 76800;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic            last;
        logic [PX_W-1:0] data;
    } px_entry_t;

endpackage

// File: rtl/fb_scan_ctrl_if.sv
// Bus bundle between the scan controller and its neighbours.
//   px_*   : pixel stream towards the LCD timing engine (valid/ready)
//   wr_*   : host pixel-write port (valid/ready, error pulse)
//   fb_*   : framebuffer RAM read and write ports
// master = the controller, slave = the surrounding logic / RAM.
interface fb_scan_ctrl_if;
    import fb_scan_ctrl_pkg::*;

    logic              px_valid;
    logic              px_ready;
    logic [PX_W-1:0]   px_data;
    logic              px_last;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PX_W-1:0]   wr_data;
    logic              wr_err;

    logic [ADDR_W-1:0] fb_rad;
    logic [PX_W-1:0]   fb_rdata;
    logic [ADDR_W-1:0] fb_wad;
    logic [PX_W-1:0]   fb_wdata;
    logic              fb_wre;

    modport master (
        output px_valid, px_data, px_last,
        input  px_ready,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, wr_err,
        output fb_rad, fb_wad, fb_wdata, fb_wre,
        input  fb_rdata
    );

    modport slave (
        input  px_valid, px_data, px_last,
        output px_ready,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, wr_err,
        input  fb_rad, fb_wad, fb_wdata, fb_wre,
        output fb_rdata
    );

endinterface

// File: rtl/fb_prefetch_fifo.sv
// Small shift-register FIFO holding prefetched pixels.
// The head entry is always mem[0], so dout and nonempty come straight from flops.
//   clk, rst        : clock, async active-high reset
//   push, din       : write an entry (ignored when full and not popping)
//   pop             : remove the head entry (ignored when empty)
//   flush           : drop all entries; overrides push/pop
//   dout, nonempty  : head entry and its valid flag
//   count           : number of stored entries
module fb_prefetch_fifo
    import fb_scan_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  px_entry_t                din,
    output px_entry_t                dout,
    output logic                     nonempty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    px_entry_t      mem [DEPTH];
    logic           do_pop;
    logic           do_push;
    logic [CW-1:0]  wr_pos;
    logic [CW-1:0]  count_nxt;

    // Write slot shifts down by one when a pop happens in the same cycle.
    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && (do_pop || (count < CW'(DEPTH)));
        wr_pos    = do_pop ? (count - CW'(1)) : count;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage, occupancy and registered non-empty flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            nonempty <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (do_push) begin
                mem[wr_pos[AW-1:0]] <= din;
            end
            count    <= count_nxt;
            nonempty <= (count_nxt != '0);
        end
    end

    assign dout = mem[0];

endmodule

// File: rtl/fb_scan_ctrl.sv
// Framebuffer scan controller: owns both RAM ports, streams pixels in raster
// order through a prefetch FIFO and forwards bounds-checked host writes.
//   clk, rst    : clock, async active-high reset
//   frame_start : pulse that (re)starts a scan at address 0
//   busy        : high while scanning or draining
//   bus         : pixel stream, host write port and RAM ports (master side)
module fb_scan_ctrl
    import fb_scan_ctrl_pkg::*;
#(
    parameter int unsigned FB_SIZE    = FB_SIZE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    output logic          busy,
    fb_scan_ctrl_if.master bus
);

    localparam int unsigned       CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    scan_state_t       state;
    logic [ADDR_W-1:0] rd_ptr;
    // s1: address on fb_rad this cycle; s2: its data on fb_rdata this cycle.
    logic              s1_vld;
    logic              s1_last;
    logic              s2_vld;
    logic              s2_last;
    logic [CW-1:0]     fifo_count;
    logic              fifo_pop;
    logic              can_issue;
    logic              pipe_empty;
    px_entry_t         fifo_din;
    px_entry_t         fifo_dout;

    assign fifo_pop   = bus.px_valid && bus.px_ready;
    assign fifo_din   = '{last: s2_last, data: bus.fb_rdata};
    // Reads still in the RAM pipeline are counted so they always find a slot.
    assign can_issue  = (32'(fifo_count) + 32'(s1_vld) + 32'(s2_vld)) < FIFO_DEPTH;
    assign pipe_empty = (fifo_count == '0) && !s1_vld && !s2_vld;

    fb_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s2_vld),
        .pop      (fifo_pop),
        .flush    (frame_start),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .nonempty (bus.px_valid),
        .count    (fifo_count)
    );

    assign bus.px_data = fifo_dout.data;
    assign bus.px_last = fifo_dout.last;

    // Scan sequencer. frame_start issues address 0 on the same edge so the
    // first pixel arrives two cycles later; clearing s1/s2 discards stale reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            bus.fb_rad <= '0;
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            s2_vld     <= 1'b0;
            s2_last    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s1_vld  <= 1'b0;
            if (frame_start) begin
                bus.fb_rad <= '0;
                rd_ptr     <= ADDR_W'(1);
                s1_vld     <= 1'b1;
                s1_last    <= (LAST_ADDR == '0);
                s2_vld     <= 1'b0;
                busy       <= 1'b1;
                state      <= (LAST_ADDR == '0) ? ST_DRAIN : ST_SCAN;
            end else begin
                case (state)
                    ST_SCAN: begin
                        if (can_issue) begin
                            bus.fb_rad <= rd_ptr;
                            rd_ptr     <= rd_ptr + ADDR_W'(1);
                            s1_vld     <= 1'b1;
                            s1_last    <= (rd_ptr == LAST_ADDR);
                            if (rd_ptr == LAST_ADDR) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pipe_empty) begin
                            rd_ptr <= '0;
                            if (CONTINUOUS) begin
                                state <= ST_SCAN;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_IDLE: begin
                        rd_ptr <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Host write port: always ready outside reset, one-cycle RAM write or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_ready <= 1'b0;
            bus.wr_err   <= 1'b0;
            bus.fb_wre   <= 1'b0;
            bus.fb_wad   <= '0;
            bus.fb_wdata <= '0;
        end else begin
            bus.wr_ready <= 1'b1;
            bus.wr_err   <= 1'b0;
            bus.fb_wre   <= 1'b0;
            if (bus.wr_valid && bus.wr_ready) begin
                if (bus.wr_addr < ADDR_W'(FB_SIZE)) begin
                    bus.fb_wre   <= 1'b1;
                    bus.fb_wad   <= bus.wr_addr;
                    bus.fb_wdata <= bus.wr_data;
                end else begin
                    bus.wr_err <= 1'b1;
                end
            end
        end
    end

endmodule
